scroll_ctrl: RTL

Sequencing controller for the scrolling-image address generator. Owns the horizontal scroll position (0..IMG_W-1) and advances it only at frame boundaries, so the image never tears mid-frame. Implements a play/pause/fast-scan/stop state machine driven by one-cycle button pulses, a frame-rate divider for speed, and a pending single-step nudge while paused. Its `position` output feeds the pixel-address generator's column offset.

---
 rtl/scroll_pkg.sv | 20 ++
 rtl/scroll_step.sv | 41 ++++
 rtl/scroll_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// Shared types and default geometry for the scrolling-image sequencer.
package scroll_pkg;

    localparam int IMG_W_DEF       = 260;
    localparam int FAST_STEP_DEF   = 4;
    localparam int FAST_FRAMES_DEF = 30;
    localparam int POS_W           = 10;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FAST  = 2'd3
    } state_e;

    function automatic logic is_playing(input state_e st);
        return (st == ST_PLAY) || (st == ST_FAST);
    endfunction

endpackage

// File: rtl/scroll_step.sv
// Modular add/subtract of a step onto the scroll position, flagging wrap-around.
import scroll_pkg::*;

module scroll_step #(
    parameter int IMG_W = IMG_W_DEF
) (
    input  logic [POS_W-1:0] i_pos,
    input  logic [POS_W-1:0] i_step,
    input  logic             i_dir,
    output logic [POS_W-1:0] o_pos,
    output logic             o_wrap
);

    logic [POS_W:0] w_sum;
    logic           w_fwd_wrap;
    logic           w_bwd_wrap;

    // Wrap decisions are made at 11 bits; the low 10 bits of the result are exact mod 1024.
    assign w_sum      = {1'b0, i_pos} + {1'b0, i_step};
    assign w_fwd_wrap = (w_sum >= (POS_W+1)'(IMG_W));
    assign w_bwd_wrap = (i_pos < i_step);

    always_comb begin
        if (i_dir) begin
            o_wrap = w_bwd_wrap;
            if (w_bwd_wrap) begin
                o_pos = i_pos + POS_W'(IMG_W) - i_step;
            end else begin
                o_pos = i_pos - i_step;
            end
        end else begin
            o_wrap = w_fwd_wrap;
            if (w_fwd_wrap) begin
                o_pos = i_pos + i_step - POS_W'(IMG_W);
            end else begin
                o_pos = i_pos + i_step;
            end
        end
    end

endmodule

// File: rtl/scroll_ctrl.sv
// Play/pause/fast/stop sequencer owning the horizontal scroll offset; steps only on frame_start.
import scroll_pkg::*;

module scroll_ctrl #(
    parameter int IMG_W       = IMG_W_DEF,
    parameter int FAST_STEP   = FAST_STEP_DEF,
    parameter int FAST_FRAMES = FAST_FRAMES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_frame_start,
    input  logic             i_btn_pause,
    input  logic             i_btn_stop,
    input  logic             i_btn_forward,
    input  logic             i_btn_backward,
    input  logic             i_track_change,
    input  logic [1:0]       i_speed,
    output logic [POS_W-1:0] o_position,
    output logic             o_playing,
    output logic             o_dir,
    output logic             o_wrap
);

    localparam int FC_W = $clog2(FAST_FRAMES + 1);

    state_e           r_state;
    logic [POS_W-1:0] r_position;
    logic             r_dir;
    logic             r_playing;
    logic             r_wrap;
    logic [1:0]       r_fcnt;
    logic [FC_W-1:0]  r_fast;
    logic             r_nudge;

    state_e           w_state_ev;
    logic [POS_W-1:0] w_pos_ev;
    logic             w_dir_ev;
    logic [1:0]       w_fcnt_ev;
    logic [FC_W-1:0]  w_fast_ev;
    logic             w_nudge_ev;

    state_e           w_state_nx;
    logic [1:0]       w_fcnt_nx;
    logic [FC_W-1:0]  w_fast_nx;
    logic             w_nudge_nx;
    logic             w_do_step;
    logic [POS_W-1:0] w_step_amt;
    logic [POS_W-1:0] w_step_pos;
    logic             w_step_wrap;

    // Button events: only the highest-priority pulse of the cycle is applied.
    always_comb begin
        w_state_ev = r_state;
        w_pos_ev   = r_position;
        w_dir_ev   = r_dir;
        w_fcnt_ev  = r_fcnt;
        w_fast_ev  = r_fast;
        w_nudge_ev = r_nudge;
        if (i_btn_stop) begin
            w_state_ev = ST_STOP;
            w_pos_ev   = '0;
            w_fcnt_ev  = 2'd0;
            w_fast_ev  = '0;
            w_nudge_ev = 1'b0;
        end else if (i_track_change) begin
            w_state_ev = ST_PLAY;
            w_pos_ev   = '0;
            w_dir_ev   = 1'b0;
            w_fcnt_ev  = 2'd0;
            w_fast_ev  = '0;
            w_nudge_ev = 1'b0;
        end else if (i_btn_pause) begin
            case (r_state)
                ST_STOP:  w_state_ev = ST_PLAY;
                ST_PLAY:  w_state_ev = ST_PAUSE;
                ST_PAUSE: w_state_ev = ST_PLAY;
                ST_FAST: begin
                    w_state_ev = ST_PAUSE;
                    w_fast_ev  = '0;
                end
                default:  w_state_ev = ST_STOP;
            endcase
        end else if (i_btn_forward || i_btn_backward) begin
            w_dir_ev = !i_btn_forward;
            case (r_state)
                ST_PLAY, ST_FAST: begin
                    w_state_ev = ST_FAST;
                    w_fast_ev  = FC_W'(FAST_FRAMES);
                end
                ST_PAUSE: w_nudge_ev = 1'b1;
                default:  w_nudge_ev = r_nudge;
            endcase
        end else begin
            w_state_ev = r_state;
        end
    end

    // Frame processing, applied on top of the post-event state.
    always_comb begin
        w_state_nx = w_state_ev;
        w_fcnt_nx  = w_fcnt_ev;
        w_fast_nx  = w_fast_ev;
        w_nudge_nx = w_nudge_ev;
        w_do_step  = 1'b0;
        w_step_amt = POS_W'(1);
        if (i_frame_start) begin
            case (w_state_ev)
                ST_PLAY: begin
                    if (w_fcnt_ev == i_speed) begin
                        w_do_step = 1'b1;
                        w_fcnt_nx = 2'd0;
                    end else begin
                        w_fcnt_nx = w_fcnt_ev + 2'd1;
                    end
                end
                ST_FAST: begin
                    w_do_step  = 1'b1;
                    w_step_amt = POS_W'(FAST_STEP);
                    if (w_fast_ev <= FC_W'(1)) begin
                        w_fast_nx  = '0;
                        w_state_nx = ST_PLAY;
                        w_fcnt_nx  = 2'd0;
                    end else begin
                        w_fast_nx = w_fast_ev - FC_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (w_nudge_ev) begin
                        w_do_step  = 1'b1;
                        w_nudge_nx = 1'b0;
                    end else begin
                        w_nudge_nx = w_nudge_ev;
                    end
                end
                default: w_do_step = 1'b0;
            endcase
        end else begin
            w_do_step = 1'b0;
        end
    end

    scroll_step #(.IMG_W(IMG_W)) u_step (
        .i_pos  (w_pos_ev),
        .i_step (w_step_amt),
        .i_dir  (w_dir_ev),
        .o_pos  (w_step_pos),
        .o_wrap (w_step_wrap)
    );

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_STOP;
            r_position <= '0;
            r_dir      <= 1'b0;
            r_playing  <= 1'b0;
            r_wrap     <= 1'b0;
            r_fcnt     <= 2'd0;
            r_fast     <= '0;
            r_nudge    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_position <= w_do_step ? w_step_pos : w_pos_ev;
            r_dir      <= w_dir_ev;
            r_playing  <= is_playing(w_state_nx);
            r_wrap     <= w_do_step & w_step_wrap;
            r_fcnt     <= w_fcnt_nx;
            r_fast     <= w_fast_nx;
            r_nudge    <= w_nudge_nx;
        end
    end

    assign o_position = r_position;
    assign o_playing  = r_playing;
    assign o_dir      = r_dir;
    assign o_wrap     = r_wrap;

endmodule
